// File: rtl/lif_layer_scheduler_pkg.sv
// rtl/lif_layer_scheduler_pkg.sv - shared constants, saturation helpers and FSM state type for the LIF layer
package lif_pkg;

  localparam int NBITS_DEF = 6;

  function automatic int sat_max(input int nbits);
    return (2 ** (nbits - 1)) - 1;
  endfunction

  function automatic int sat_min(input int nbits);
    return -(2 ** (nbits - 1));
  endfunction

  localparam int SAT_MAX = sat_max(NBITS_DEF);
  localparam int SAT_MIN = sat_min(NBITS_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/lif_layer_scheduler_if.sv
// rtl/lif_layer_scheduler_if.sv - timestep handshake between sequencer and LIF layer scheduler
// Signals: start, clear_state (sequencer -> layer); busy, done, spike_vec (layer -> sequencer).
// master = timestep sequencer side, slave = layer scheduler side.
interface lif_layer_scheduler_if #(
  parameter int NUM_NEURONS = 8
);
  logic                   start;
  logic                   clear_state;
  logic                   busy;
  logic                   done;
  logic [NUM_NEURONS-1:0] spike_vec;

  modport master (
    output start, clear_state,
    input  busy, done, spike_vec
  );

  modport slave (
    input  start, clear_state,
    output busy, done, spike_vec
  );
endinterface

// File: rtl/lif_layer_scheduler_update_core.sv
// rtl/lif_layer_scheduler_update_core.sv - combinational single-neuron leaky integrate-and-fire update
// Inputs : v (potential), r (refractory count), i (current), threshold, decay, refractory_period.
// Outputs: v_next, r_next, spike.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic [NBITS-1:0] v,
  input  logic [NBITS-1:0] r,
  input  logic [NBITS-1:0] i,
  input  logic [NBITS-1:0] threshold,
  input  logic [NBITS-1:0] decay,
  input  logic [NBITS-1:0] refractory_period,
  output logic [NBITS-1:0] v_next,
  output logic [NBITS-1:0] r_next,
  output logic             spike
);

  // Two guard bits cover V + I +/- decay without overflow before clamping.
  localparam int W = NBITS + 2;
  localparam logic signed [W-1:0] HI = W'(sat_max(NBITS));
  localparam logic signed [W-1:0] LO = W'(sat_min(NBITS));

  logic signed [W-1:0] v_ext, i_ext, d_ext, leak, sum, sat;

  always_comb begin
    v_ext = $signed({{2{v[NBITS-1]}}, v});
    i_ext = $signed({{2{i[NBITS-1]}}, i});
    d_ext = $signed({{2{decay[NBITS-1]}}, decay});
    // Leak always pulls the potential toward zero.
    leak  = v[NBITS-1] ? d_ext : -d_ext;
    sum   = v_ext + i_ext + leak;
    if (sum > HI)      sat = HI;
    else if (sum < LO) sat = LO;
    else               sat = sum;
  end

  always_comb begin
    v_next = v;
    r_next = r;
    spike  = 1'b0;
    if (r != '0) begin
      r_next = r - 1'b1;
    end else if ($signed(v) >= $signed(threshold)) begin
      spike  = 1'b1;
      v_next = v - threshold;
      r_next = refractory_period;
    end else begin
      v_next = sat[NBITS-1:0];
    end
  end

endmodule

// File: rtl/lif_layer_scheduler.sv
// rtl/lif_layer_scheduler.sv - time-multiplexed LIF layer: one shared update core, per-neuron state storage
// Ports: clk, reset (async, active-high); ctl (slave: start, clear_state, busy, done, spike_vec);
//        input_current_flat (neuron i at [i*NBITS +: NBITS]), threshold, decay, refractory_period;
//        dbg_idx -> dbg_potential (combinational potential read).
module lif_layer_scheduler
  import lif_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int NBITS       = NBITS_DEF,
  parameter int IDX_W       = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  lif_layer_scheduler_if.slave         ctl,
  input  logic [NUM_NEURONS*NBITS-1:0] input_current_flat,
  input  logic [NBITS-1:0]             threshold,
  input  logic [NBITS-1:0]             decay,
  input  logic [NBITS-1:0]             refractory_period,
  input  logic [IDX_W-1:0]             dbg_idx,
  output logic [NBITS-1:0]             dbg_potential
);

  state_t state, state_nxt;

  logic [IDX_W-1:0]             idx;
  logic [NUM_NEURONS*NBITS-1:0] cur_sh;
  logic [NBITS-1:0]             thr_sh, dec_sh, per_sh;
  logic [NBITS-1:0]             v_mem [NUM_NEURONS];
  logic [NBITS-1:0]             r_mem [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       spike_acc, acc_nxt, spike_vec_q;

  logic             last, take_start, do_clear;
  logic [NBITS-1:0] core_v, core_r;
  logic             core_spike;

  assign last       = (idx == IDX_W'(NUM_NEURONS - 1));
  // Clear has priority over start when both arrive in IDLE.
  assign do_clear   = (state == IDLE) && ctl.clear_state;
  assign take_start = (state == IDLE) && ctl.start && !ctl.clear_state;

  lif_update_core #(.NBITS(NBITS)) u_core (
    .v                 (v_mem[idx]),
    .r                 (r_mem[idx]),
    .i                 (cur_sh[idx*NBITS +: NBITS]),
    .threshold         (thr_sh),
    .decay             (dec_sh),
    .refractory_period (per_sh),
    .v_next            (core_v),
    .r_next            (core_r),
    .spike             (core_spike)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_start) state_nxt = UPDATE;
      UPDATE:  if (last)       state_nxt = DONE;
      DONE:                    state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Accumulator including the neuron being written this cycle, so the final
  // neuron's spike lands in spike_vec on the same edge that enters DONE.
  always_comb begin
    acc_nxt      = spike_acc;
    acc_nxt[idx] = core_spike;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      cur_sh      <= '0;
      thr_sh      <= '0;
      dec_sh      <= '0;
      per_sh      <= '0;
      spike_acc   <= '0;
      spike_vec_q <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_mem[n] <= '0;
        r_mem[n] <= '0;
      end
    end else begin
      if (take_start) begin
        cur_sh    <= input_current_flat;
        thr_sh    <= threshold;
        dec_sh    <= decay;
        per_sh    <= refractory_period;
        idx       <= '0;
        spike_acc <= '0;
      end
      if (do_clear) begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
          v_mem[n] <= '0;
          r_mem[n] <= '0;
        end
      end
      if (state == UPDATE) begin
        v_mem[idx] <= core_v;
        r_mem[idx] <= core_r;
        spike_acc  <= acc_nxt;
        if (last) begin
          idx         <= '0;
          spike_vec_q <= acc_nxt;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  assign ctl.busy      = (state == UPDATE);
  assign ctl.done      = (state == DONE);
  assign ctl.spike_vec = spike_vec_q;
  assign dbg_potential = v_mem[dbg_idx];

endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
- Time-multiplexed controller for one layer of leaky integrate-and-fire neurons.
- One shared LIF update datapath (lif_update_core) serves all neurons. The block owns per-neuron membrane-potential and refractory-counter storage.
- On each timestep request it steps through the neurons one per cycle, writes back state, and returns the layer spike vector with a done pulse.
- Sits between the timestep sequencer (start/done) and the synapse/input stage that supplies per-neuron currents.

Parameters:
- NUM_NEURONS, 8, neurons in the layer (>=2).
- NBITS, 6, two's-complement width of potential, current, threshold, decay, refractory count.
- IDX_W, 3, index width; equals clog2(NUM_NEURONS).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  request one timestep update; honoured only in IDLE.
- clear_state  in  1  zero all potentials and counters; honoured only in IDLE.
- input_current_flat  in  NUM_NEURONS*NBITS  signed current; neuron i at bits [i*NBITS +: NBITS].
- threshold  in  NBITS  signed firing threshold, shared by all neurons.
- decay  in  NBITS  signed leak magnitude.
- refractory_period  in  NBITS  unsigned refractory length, in timesteps.
- busy  out  1  high while in UPDATE.
- done  out  1  one-cycle pulse when spike_vec is valid.
- spike_vec  out  NUM_NEURONS  spikes from the last completed timestep.
- dbg_idx  in  IDX_W  debug select.
- dbg_potential  out  NBITS  combinational read of the potential of neuron dbg_idx.

Behaviour:
- Reset values:
  - State = IDLE.
  - All potentials and refractory counters = 0.
  - busy = 0, done = 0, spike_vec = 0, index = 0.
- Reset mid-UPDATE aborts the timestep and leaves no partial spike_vec.
- FSM states: IDLE, UPDATE, DONE.
  - IDLE -> UPDATE on start. At that edge, capture input_current_flat, threshold, decay and refractory_period into shadow registers. The captured values are used for the whole timestep.
  - UPDATE: neuron index runs 0..NUM_NEURONS-1, one neuron per cycle. When the edge that writes neuron NUM_NEURONS-1 occurs, go to DONE.
  - DONE -> IDLE after one cycle. done = 1 only in DONE. spike_vec loads from the spike accumulator on entry to DONE and holds until the next DONE.
- Latency: start sampled at edge t0; neuron i is written at edge t(i+1); done is high during the cycle after edge t(NUM_NEURONS). Total = NUM_NEURONS+1 cycles from start to done.
- start while busy or during DONE: ignored, not queued.
- clear_state in IDLE: all potentials and counters go to 0 at the next edge. spike_vec is unchanged.
- start and clear_state together in IDLE: clear wins, start is dropped.
- Per-neuron update (lif_update_core), with V and R the stored values and all arithmetic sign-extended to NBITS+2:
  - sum = V + I + (V<0 ? +decay : -decay).
  - Saturate sum to [-2^(NBITS-1), 2^(NBITS-1)-1].
  - If R>0: R <= R-1, V unchanged, no spike.
  - Else if signed V >= signed threshold: spike = 1, V <= V - threshold (NBITS wrap), R <= refractory_period. The threshold compare uses the old V.
  - Else: V <= saturated sum, no spike.
- The spike accumulator is cleared on the start edge.

Decomposition:
- Package lif_pkg holds:
  - NBITS default.
  - SAT_MAX / SAT_MIN constants.
  - FSM state enum {IDLE, UPDATE, DONE}.
- Sub-module lif_update_core: purely combinational. Inputs V, R, I, threshold, decay, refractory_period. Outputs V_next, R_next, spike.
- Storage arrays and FSM stay in lif_layer_scheduler.

Test Plan:
- Integrate then fire. Setup: NUM_NEURONS=4, all I=5, threshold=10, decay=1, period=2. Seven timesteps -> V per round 4, 8, 12, then spike_vec=4'b1111 with V=2, R=2; two silent rounds with V=2; round 7 V=6.
- Positive saturation. Setup: I=31, threshold=31, decay=1. Round 1 V=30; round 2 V=31 (saturated), no spike; round 3 spike, V=0.
- Negative saturation. Setup: I=-32, decay=1. Round 1 V=-32; round 2 V=-32 (sum -63 clamped); no spikes.
- Timing. Pulse start -> busy high for exactly 4 cycles, done high for 1 cycle 5 cycles after start. A start asserted during busy produces no second done.
- Clear and reset.
  - start and clear_state together in IDLE -> potentials 0, no busy.
  - Reset asserted mid-UPDATE -> dbg_potential = 0 for every idx, done never pulses.
- Per-neuron currents. Distinct I per neuron (1, 2, 3, 4), threshold=3 -> spike_vec=4'b0000 after round 1, 4'b1000 after round 2.
